bin2bcd_serial: RTL and testbench

Sequential binary-to-BCD converter using iterative shift-add-3 (double dabble). It sits directly downstream of the up/down counter and upstream of the per-digit 7-segment BCD decoders. It replaces combinational %10 and /10 arithmetic with an IN_W-cycle iterative conversion that uses a start/done handshake. Each BCD nibble drives one display decoder: units, tens, hundreds.

---
 rtl/bin2bcd_serial_pkg.sv | 29 ++
 rtl/bcd_digit_adj.sv | 19 +
 rtl/bin2bcd_serial.sv | 99 +++++++++
 tb/tb_bin2bcd_serial.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_serial_pkg.sv
// Shared types and constants for the serial double-dabble binary-to-BCD converter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bin2bcd_serial_pkg;

  // Converter control states: waiting, iterating over input bits, result pulse.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Bits per BCD digit.
  localparam int NIBBLE_W = 4;

  // A digit at or above this value would exceed 9 after doubling, so it gets +3 first.
  localparam logic [NIBBLE_W-1:0] ADD3_THRESH = 4'd5;

  // 10^n, used to flag inputs that do not fit in the available digits.
  function automatic longint unsigned pow10(input int n);
    longint unsigned acc;
    acc = 64'd1;
    for (int i = 0; i < n; i++) begin
      acc = acc * 64'd10;
    end
    return acc;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the input digit.
module bcd_digit_adj
  import bin2bcd_serial_pkg::*;
(
  input  logic [NIBBLE_W-1:0] digit_in,
  output logic [NIBBLE_W-1:0] digit_out
);

  // Pre-shift correction so the following left shift carries cleanly into the next digit.
  always_comb begin
    digit_out = digit_in;
    if (digit_in >= ADD3_THRESH) begin
      digit_out = digit_in + 4'd3;
    end
  end

endmodule

// File: rtl/bin2bcd_serial.sv
// Iterative binary-to-BCD converter (shift-add-3), one input bit per cycle.
// Latency: start accepted at edge N -> done pulse in the cycle after edge N+IN_W.
// Backpressure: start is ignored while busy; a new request is taken in IDLE or in the DONE cycle.
module bin2bcd_serial
  import bin2bcd_serial_pkg::*;
#(
  parameter int IN_W   = 7,
  parameter int DIGITS = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [IN_W-1:0]            bin_in,
  output logic                       busy,
  output logic                       done,
  output logic [NIBBLE_W*DIGITS-1:0] bcd_out,
  output logic                       overflow
);

  localparam int SCR_W = NIBBLE_W * DIGITS;
  localparam int CNT_W = $clog2(IN_W + 1);
  localparam int CAT_W = SCR_W + IN_W;
  localparam longint unsigned LIMIT = pow10(DIGITS);

  state_e           state;
  logic [IN_W-1:0]  bin_reg;
  logic [SCR_W-1:0] scratch;
  logic [SCR_W-1:0] scratch_adj;
  logic [CAT_W-1:0] cat_shift;
  logic [CNT_W-1:0] bit_cnt;
  logic             ovf_pend;
  logic             accept;
  logic             in_ovf;

  // A request is taken when the converter is not iterating; DONE accepts for back-to-back use.
  assign accept = start && ((state == ST_IDLE) || (state == ST_DONE));

  // Values that need more digits than available are flagged; digits then hold value mod 10^DIGITS.
  assign in_ovf = (64'(bin_in) >= LIMIT);

  // One corrector per digit, all operating on the pre-shift scratch value.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_in  (scratch[g*NIBBLE_W +: NIBBLE_W]),
      .digit_out (scratch_adj[g*NIBBLE_W +: NIBBLE_W])
    );
  end

  // Shift corrected digits and remaining binary bits as one register; the top digit's carry-out falls off.
  assign cat_shift = {scratch_adj, bin_reg} << 1;

  // Control FSM and datapath registers; reset overrides any request or conversion in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      bin_reg  <= '0;
      scratch  <= '0;
      bit_cnt  <= '0;
      ovf_pend <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd_out  <= '0;
      overflow <= 1'b0;
    end else if (accept) begin
      state    <= ST_SHIFT;
      bin_reg  <= bin_in;
      scratch  <= '0;
      bit_cnt  <= CNT_W'(IN_W);
      ovf_pend <= in_ovf;
      busy     <= 1'b1;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_SHIFT: begin
          scratch <= cat_shift[CAT_W-1 -: SCR_W];
          bin_reg <= cat_shift[IN_W-1:0];
          bit_cnt <= bit_cnt - CNT_W'(1);
          if (bit_cnt == CNT_W'(1)) begin
            // Final bit consumed: publish the complete result in one step.
            state    <= ST_DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            bcd_out  <= cat_shift[CAT_W-1 -: SCR_W];
            overflow <= ovf_pend;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_serial.sv
// Bench for bin2bcd_serial: a 3-digit and a 2-digit instance with scoreboard checking.
// Latency: expects done 7 edges after the accepting edge (IN_W = 7).
// Backpressure: requests are only issued when the instance is idle or in its done cycle.
module tb_bin2bcd_serial;

  typedef struct {
    logic [11:0] bcd;
    logic        ovf;
    int          edge_n;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, start_b;
  logic [6:0]  bin_a, bin_b;
  logic        busy_a, busy_b, done_a, done_b, ovf_a, ovf_b;
  logic [11:0] bcd_a;
  logic [7:0]  bcd_b;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  always #5 clk = ~clk;

  // Edge counter: after posedge k, cyc == k.
  always @(posedge clk) cyc <= cyc + 1;

  bin2bcd_serial #(.IN_W(7), .DIGITS(3)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .bin_in(bin_a),
    .busy(busy_a), .done(done_a), .bcd_out(bcd_a), .overflow(ovf_a)
  );

  bin2bcd_serial #(.IN_W(7), .DIGITS(2)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .bin_in(bin_b),
    .busy(busy_b), .done(done_b), .bcd_out(bcd_b), .overflow(ovf_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor for the 3-digit instance: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (done_a === 1'b1) begin
      if (q_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected_done: got bcd %0h with no request outstanding", bcd_a);
      end else begin
        exp_t e;
        e = q_a.pop_front();
        check("a_bcd", 32'(bcd_a), 32'(e.bcd));
        check("a_ovf", 32'(ovf_a), 32'(e.ovf));
        check("a_latency", 32'(cyc - e.edge_n), 32'd7);
      end
    end
  end

  // Monitor for the 2-digit instance.
  always @(negedge clk) begin
    if (done_b === 1'b1) begin
      if (q_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected_done: got bcd %0h with no request outstanding", bcd_b);
      end else begin
        exp_t e;
        e = q_b.pop_front();
        check("b_bcd", 32'(bcd_b), 32'(e.bcd));
        check("b_ovf", 32'(ovf_b), 32'(e.ovf));
        check("b_latency", 32'(cyc - e.edge_n), 32'd7);
      end
    end
  end

  task automatic issue_a(input logic [6:0] v, input logic [11:0] exp_bcd, input logic exp_ovf);
    @(negedge clk);
    start_a = 1'b1;
    bin_a   = v;
    @(posedge clk);
    #1;
    q_a.push_back('{exp_bcd, exp_ovf, cyc});
    start_a = 1'b0;
  endtask

  task automatic issue_b(input logic [6:0] v, input logic [11:0] exp_bcd, input logic exp_ovf);
    @(negedge clk);
    start_b = 1'b1;
    bin_b   = v;
    @(posedge clk);
    #1;
    q_b.push_back('{exp_bcd, exp_ovf, cyc});
    start_b = 1'b0;
  endtask

  task automatic drain(input bit sel_b);
    for (int i = 0; i < 40; i++) begin
      if ((sel_b ? q_b.size() : q_a.size()) == 0) break;
      @(negedge clk);
    end
    if ((sel_b ? q_b.size() : q_a.size()) != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d results outstanding, expected 0",
               sel_b ? "b" : "a", sel_b ? q_b.size() : q_a.size());
      if (sel_b) q_b.delete(); else q_a.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [6:0] step_seq [3];
    step_seq[0] = 7'd5;
    step_seq[1] = 7'd6;
    step_seq[2] = 7'd7;

    rst = 1'b1; start_a = 1'b1; bin_a = 7'd100; start_b = 1'b0; bin_b = 7'd0;

    // Reset held for two edges with start asserted.
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst_busy_a", 32'(busy_a), 32'd0);
    check("rst_done_a", 32'(done_a), 32'd0);
    check("rst_bcd_a",  32'(bcd_a),  32'h000);
    check("rst_ovf_a",  32'(ovf_a),  32'd0);
    check("rst_busy_b", 32'(busy_b), 32'd0);
    check("rst_bcd_b",  32'(bcd_b),  32'h00);
    rst = 1'b0;
    start_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("idle_busy_a", 32'(busy_a), 32'd0);

    // 127: busy for seven cycles, then a single done cycle.
    issue_a(7'd127, 12'h127, 1'b0);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      check("t127_busy_hi", 32'(busy_a), 32'd1);
      check("t127_done_lo", 32'(done_a), 32'd0);
    end
    @(negedge clk);
    check("t127_done_hi", 32'(done_a), 32'd1);
    check("t127_busy_lo", 32'(busy_a), 32'd0);
    drain(1'b0);

    // Zero takes the full latency; then 99.
    issue_a(7'd0, 12'h000, 1'b0);
    drain(1'b0);
    issue_a(7'd99, 12'h099, 1'b0);
    drain(1'b0);

    // start held high, bin_in cycling 5,6,7 each edge: accepted at +0, +8, +16.
    @(negedge clk);
    start_a = 1'b1;
    bin_a   = step_seq[0];
    for (int i = 0; i < 24; i++) begin
      @(posedge clk);
      #1;
      if (i == 0)  q_a.push_back('{12'h005, 1'b0, cyc});
      if (i == 8)  q_a.push_back('{12'h007, 1'b0, cyc});
      if (i == 16) q_a.push_back('{12'h006, 1'b0, cyc});
      bin_a = step_seq[(i + 1) % 3];
    end
    start_a = 1'b0;
    drain(1'b0);

    // Reset during the conversion of 45 aborts it and clears the result.
    @(negedge clk);
    start_a = 1'b1;
    bin_a   = 7'd45;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    bin_a   = 7'd0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy_a), 32'd0);
    check("abort_done", 32'(done_a), 32'd0);
    check("abort_bcd",  32'(bcd_a),  32'h000);
    repeat (12) @(negedge clk);
    issue_a(7'd45, 12'h045, 1'b0);
    drain(1'b0);

    // Two-digit instance: truncation with overflow, exact boundary, then an in-range value.
    issue_b(7'd127, 12'h027, 1'b1);
    drain(1'b1);
    issue_b(7'd100, 12'h000, 1'b1);
    drain(1'b1);
    issue_b(7'd99, 12'h099, 1'b0);
    drain(1'b1);

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
